// File: rtl/alarm_pkg.sv
// Shared state encoding and BCD field limits for the alarm sequencer.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EDIT_HR  = 3'd1,
    ST_EDIT_MIN = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_ARMED    = 3'd4,
    ST_RINGING  = 3'd5,
    ST_SNOOZE   = 3'd6
  } state_e;

  localparam logic [7:0] HR_MAX  = 8'h23;
  localparam logic [7:0] MIN_MAX = 8'h59;

endpackage

// File: rtl/alarm_bcd_field_inc.sv
// Two-digit BCD increment with wrap to 00 once MAX is reached.
// Purely combinational; zero latency, no flow control.
module bcd_field_inc #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic [7:0] val_i,
  output logic [7:0] val_o
);

  always_comb begin
    val_o = 8'h00;
    if (val_i == MAX) begin
      val_o = 8'h00;
    end else if (val_i[3:0] == 4'd9) begin
      val_o = {val_i[7:4] + 4'd1, 4'd0};
    end else begin
      val_o = {val_i[7:4], val_i[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm edit dialogue, delayed load into the compare pipeline and timed buzzer sequencing.
// All outputs registered; snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int LOAD_DLY    = 3,
  parameter int RING_SECS   = 60,
`ifdef ALARM_SNOOZE_EN
  parameter int SNOOZE_SECS = 300,
`endif
  parameter int CNT_W       = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        key_set,
  input  logic        key_inc,
  input  logic        key_stop,
  input  logic        alarm_en,
  input  logic        ring_match,
  output logic        load,
  output logic [15:0] load_data,
  output logic        buzz,
  output logic [2:0]  state_o
);

  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_DLY);
`ifdef ALARM_SNOOZE_EN
  localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNOOZE_SECS - 1);
`endif

  state_e           state_q;
  logic [7:0]       hr_q, min_q, hr_inc, min_inc;
  logic [15:0]      cmt_q;
  logic [CNT_W-1:0] sec_cnt_q, dly_cnt_q;
  logic             load_q, buzz_q, armed_q, match_q, from_armed_q;
  logic             match_ev;

  bcd_field_inc #(.MAX(HR_MAX))  u_hr_inc  (.val_i(hr_q),  .val_o(hr_inc));
  bcd_field_inc #(.MAX(MIN_MAX)) u_min_inc (.val_i(min_q), .val_o(min_inc));

  // match_q resets high so the compare block's post-reset 0000==0000 is not an edge
  assign match_ev  = ring_match & ~match_q;
  assign load      = load_q;
  assign load_data = {hr_q, min_q};
  assign buzz      = buzz_q;
  assign state_o   = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hr_q         <= 8'h00;
      min_q        <= 8'h00;
      cmt_q        <= 16'h0000;
      sec_cnt_q    <= '0;
      dly_cnt_q    <= '0;
      load_q       <= 1'b0;
      buzz_q       <= 1'b0;
      armed_q      <= 1'b0;
      match_q      <= 1'b1;
      from_armed_q <= 1'b0;
    end else begin
      match_q <= ring_match;
      load_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!key_stop && key_set) begin
            state_q      <= ST_EDIT_HR;
            from_armed_q <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (!key_stop && key_set) begin
            state_q      <= ST_EDIT_HR;
            from_armed_q <= 1'b1;
          end else if (!alarm_en) begin
            state_q <= ST_IDLE;
          end else if (match_ev && armed_q) begin
            state_q   <= ST_RINGING;
            buzz_q    <= 1'b1;
            sec_cnt_q <= '0;
          end
        end
        ST_EDIT_HR, ST_EDIT_MIN: begin
          if (key_stop) begin
            state_q <= from_armed_q ? ST_ARMED : ST_IDLE;
            hr_q    <= cmt_q[15:8];
            min_q   <= cmt_q[7:0];
          end else if (key_set) begin
            if (state_q == ST_EDIT_HR) begin
              state_q <= ST_EDIT_MIN;
            end else begin
              state_q   <= ST_COMMIT;
              dly_cnt_q <= '0;
              load_q    <= (LOAD_DLY == 0);
            end
          end else if (key_inc) begin
            if (state_q == ST_EDIT_HR) hr_q  <= hr_inc;
            else                       min_q <= min_inc;
          end
        end
        ST_COMMIT: begin
          // load_q is high exactly while dly_cnt_q == LOAD_LAST, the exit cycle
          if (dly_cnt_q == LOAD_LAST) begin
            state_q <= alarm_en ? ST_ARMED : ST_IDLE;
            armed_q <= 1'b1;
            cmt_q   <= {hr_q, min_q};
          end else begin
            dly_cnt_q <= dly_cnt_q + CNT_W'(1);
            load_q    <= ((dly_cnt_q + CNT_W'(1)) == LOAD_LAST);
          end
        end
        ST_RINGING: begin
          if (!alarm_en) begin
            state_q <= ST_IDLE;
            buzz_q  <= 1'b0;
          end else if (key_stop) begin
            state_q <= ST_ARMED;
            buzz_q  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (!key_set && key_inc) begin
            state_q   <= ST_SNOOZE;
            buzz_q    <= 1'b0;
            sec_cnt_q <= '0;
`endif
          end else if (tick_1hz) begin
            if (sec_cnt_q == RING_LAST) begin
              state_q <= ST_ARMED;
              buzz_q  <= 1'b0;
            end else begin
              sec_cnt_q <= sec_cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (!alarm_en) begin
            state_q <= ST_IDLE;
          end else if (key_stop) begin
            state_q <= ST_ARMED;
          end else if (tick_1hz) begin
            if (sec_cnt_q == SNZ_LAST) begin
              state_q   <= ST_RINGING;
              buzz_q    <= 1'b1;
              sec_cnt_q <= '0;
            end else begin
              sec_cnt_q <= sec_cnt_q + CNT_W'(1);
            end
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          buzz_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
